// File: rtl/alu_pkg.sv
// alu_pkg: shared op, decode-constant and FSM-state definitions for the ALU execute unit
package alu_pkg;
  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, ILLEGAL
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;
  localparam logic [2:0] ALUOP_R = 3'b010;
  localparam logic [2:0] ALUOP_I = 3'b001;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_M    = 7'h01;
  function automatic logic is_div_op(input alu_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction
endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: iterative restoring divider (one quotient bit per cycle) with signed pre/post
// correction and RISC-V divide-by-zero / overflow results.
// Ports: start latches a/b/is_signed/is_rem; busy is high for XLEN step cycles; done flags the
// final step cycle; result is valid from the cycle after done until the next start.
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  input  logic            is_rem,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic zero_q, zero_d, ovf_q, ovf_d, sel_rem_q, sel_rem_d;
  logic a_neg, b_neg;
  logic [XLEN:0] sh, diff;
  logic [XLEN-1:0] q_fix, r_fix;
  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  // Partial remainder shifted left with the next dividend bit; a borrow in diff means "restore".
  assign sh    = {rem_q, quo_q[XLEN-1]};
  assign diff  = sh - {1'b0, dvs_q};
  assign busy  = busy_q;
  assign done  = busy_q && cnt_q == CW'(XLEN-1);
  assign q_fix = qneg_q ? -quo_q : quo_q;
  assign r_fix = rneg_q ? -rem_q : rem_q;
  assign result = zero_q ? (sel_rem_q ? a_q : '1) :
                  ovf_q  ? (sel_rem_q ? '0 : a_q) :
                  sel_rem_q ? r_fix : q_fix;
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    a_d = a_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    sel_rem_d = sel_rem_q;
    if (start) begin
      rem_d = '0;
      quo_d = a_neg ? -a : a;
      dvs_d = b_neg ? -b : b;
      a_d = a;
      cnt_d = '0;
      busy_d = 1'b1;
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      zero_d = b == '0;
      ovf_d = is_signed && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
      sel_rem_d = is_rem;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      busy_d = !done;
      rem_d = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], !diff[XLEN]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      a_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      a_q <= a_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      sel_rem_q <= sel_rem_d;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes funct3/funct7/ctrl_ALU_op, executes RV32I/RV32M ALU ops and returns a
// registered result with a one-cycle out_valid pulse.
// Ports: in_valid/in_ready request handshake; ctrl_ALU_op, funct3, funct7, op_a, op_b operation;
// out_valid, out_result, out_illegal registered response (no output backpressure).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_M    = 1'b1,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      ctrl_ALU_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);
  alu_op_e op;
  state_e state_q, state_d;
  logic out_valid_q, out_valid_d, out_illegal_q, out_illegal_d;
  logic [XLEN-1:0] out_result_q, out_result_d, alu_res, div_res;
  logic [6:0] f7_chk;
  logic [SHAMT_W-1:0] shamt;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic accept, div_start, div_busy, div_done;
  // On RV64 funct7[0] of an I-type shift is shamt[5], not part of the opcode.
  assign f7_chk = (XLEN == 64) ? {funct7[6:1], 1'b0} : funct7;
  always_comb begin
    op = ADD;
    if (ctrl_ALU_op == ALUOP_R) begin
      if (funct7 == F7_BASE) begin
        case (funct3)
          3'd0: op = ADD;
          3'd1: op = SLL;
          3'd2: op = SLT;
          3'd3: op = SLTU;
          3'd4: op = XOR;
          3'd5: op = SRL;
          3'd6: op = OR;
          3'd7: op = AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        op = funct3 == 3'd0 ? SUB : funct3 == 3'd5 ? SRA : ILLEGAL;
      end else if (funct7 == F7_M && EN_M) begin
        case (funct3)
          3'd0: op = MUL;
          3'd1: op = MULH;
          3'd2: op = MULHSU;
          3'd3: op = MULHU;
          3'd4: op = DIV;
          3'd5: op = DIVU;
          3'd6: op = REM;
          3'd7: op = REMU;
        endcase
      end else begin
        op = ILLEGAL;
      end
    end else if (ctrl_ALU_op == ALUOP_I) begin
      case (funct3)
        3'd0: op = ADD;
        3'd1: op = f7_chk == F7_BASE ? SLL : ILLEGAL;
        3'd2: op = SLT;
        3'd3: op = SLTU;
        3'd4: op = XOR;
        3'd5: op = f7_chk == F7_BASE ? SRL : f7_chk == F7_ALT ? SRA : ILLEGAL;
        3'd6: op = OR;
        3'd7: op = AND;
      endcase
    end
  end
  // One shared 2*XLEN multiplier; sign-extension of each operand selects the MULH flavour.
  assign shamt = op_b[SHAMT_W-1:0];
  assign a_ext = {{XLEN{(op == MULH || op == MULHSU) & op_a[XLEN-1]}}, op_a};
  assign b_ext = {{XLEN{(op == MULH) & op_b[XLEN-1]}}, op_b};
  assign prod  = a_ext * b_ext;
  always_comb begin
    alu_res = '0;
    case (op)
      ADD:    alu_res = op_a + op_b;
      SUB:    alu_res = op_a - op_b;
      SLL:    alu_res = op_a << shamt;
      SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      XOR:    alu_res = op_a ^ op_b;
      SRL:    alu_res = op_a >> shamt;
      SRA:    alu_res = XLEN'($signed(op_a) >>> shamt);
      OR:     alu_res = op_a | op_b;
      AND:    alu_res = op_a & op_b;
      MUL:    alu_res = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: alu_res = prod[2*XLEN-1:XLEN];
      default: alu_res = '0;
    endcase
  end
  assign in_ready  = state_q == S_IDLE && !div_busy;
  assign accept    = in_valid & in_ready;
  assign div_start = accept & is_div_op(op);
  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .a(op_a),
    .b(op_b),
    .is_signed(op == DIV || op == REM),
    .is_rem(op == REM || op == REMU),
    .busy(div_busy),
    .done(div_done),
    .result(div_res)
  );
  always_comb begin
    state_d = state_q;
    out_valid_d = 1'b0;
    out_illegal_d = 1'b0;
    out_result_d = out_result_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = is_div_op(op) ? S_DIV : S_IDLE;
        out_valid_d = !is_div_op(op);
        out_illegal_d = op == ILLEGAL;
        out_result_d = is_div_op(op) ? out_result_q : alu_res;
      end
      S_DIV: state_d = div_done ? S_DONE : S_DIV;
      S_DONE: begin
        state_d = S_IDLE;
        out_valid_d = 1'b1;
        out_result_d = div_res;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_valid_q <= 1'b0;
      out_illegal_q <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      out_illegal_q <= out_illegal_d;
      out_result_q <= out_result_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign out_illegal = out_illegal_q;
  assign out_result  = out_result_q;
endmodule
